// File: rtl/i2c_target_regport.sv
// I2C target with a 1- or 2-byte register pointer and multi-byte word streaming.
// SCL/SDA are oversampled on clk; the target only ever pulls SDA low, driven on the cycle after SCL falls.
module i2c_target_regport #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         PTR_BYTES   = 2,
    parameter int         DATA_BYTES  = 4,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int        DW          = 8 * DATA_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy
);

    // state   | meaning
    // IDLE    | waiting for START        DEV/DEV_ACK | address byte / its ACK
    // PTR/ACK | pointer bytes            WR/WR_ACK   | write data / its ACK
    // RD      | driving data byte        RD_ACK      | master ACK/NACK slot
    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [1:0]      byte_cnt_q;
    logic [6:0]      shift_q;
    logic            rw_q;
    logic [AW-1:0]   ptr_q;
    logic [DW-1:0]   word_q;
    logic [DW-1:0]   tx_q;
    logic            sda_oe_q, busy_q, wr_valid_q, rd_req_q, rd_load_q;
    logic [AW-1:0]   wr_addr_q, rd_addr_q;

    logic [7:0]      rx_byte;
    logic [AW-1:0]   ptr_load_d;
    logic [DW-1:0]   word_shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Pointer bytes shift through ptr_q so only the low AW bits of the assembled value survive.
    assign rx_byte      = {shift_q, sda_s};
    assign ptr_load_d   = AW'({ptr_q, rx_byte});
    assign word_shift_d = DW'({word_q, rx_byte});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            word_q     <= '0;
            tx_q       <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_load_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_load_q  <= rd_req_q;
            if (rd_load_q) begin
                tx_q <= rd_data;
            end

            if (start_det) begin
                state_q    <= DEV;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sda_oe_q   <= 1'b0;
            end else if (stop_det) begin
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                byte_cnt_q <= '0;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    DEV: begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_q <= DEV_ACK;
                                rw_q    <= rx_byte[0];
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    DEV_ACK: begin
                        byte_cnt_q <= '0;
                        if (rw_q) begin
                            state_q   <= RD;
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= ptr_q;
                        end else begin
                            state_q <= PTR;
                        end
                    end
                    PTR: begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            ptr_q   <= ptr_load_d;
                            state_q <= PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        if (byte_cnt_q == 2'(PTR_BYTES - 1)) begin
                            byte_cnt_q <= '0;
                            state_q    <= WR;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= PTR;
                        end
                    end
                    WR: begin
                        shift_q   <= rx_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            word_q  <= word_shift_d;
                            state_q <= WR_ACK;
                            if (byte_cnt_q == 2'(DATA_BYTES - 1)) begin
                                byte_cnt_q <= '0;
                                wr_valid_q <= 1'b1;
                                wr_addr_q  <= ptr_q;
                                ptr_q      <= ptr_q + 1'b1;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                        end
                    end
                    WR_ACK: state_q <= WR;
                    RD: begin
                        tx_q      <= tx_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        if (sda_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RD;
                            if (byte_cnt_q == 2'(DATA_BYTES - 1)) begin
                                byte_cnt_q <= '0;
                                ptr_q      <= ptr_q + 1'b1;
                                rd_req_q   <= 1'b1;
                                rd_addr_q  <= ptr_q + 1'b1;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    DEV_ACK, PTR_ACK, WR_ACK: sda_oe_q <= 1'b1;
                    RD:                       sda_oe_q <= ~tx_q[DW-1];
                    default:                  sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = word_q;
    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Bench for i2c_target_regport: a bit-level I2C master drives a 2/4-byte build and a 1/1-byte build,
// and a word-addressed memory model predicts every ACK, strobe and read byte.
module tb_i2c_target_regport;
    localparam int NR = 16;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic scl_m = 1'b1, sda_m = 1'b1, sel_b = 1'b0;
    logic scl_a, sda_a, scl_b, sda_b, bus_sda;

    logic        sda_oe_a, wr_valid_a, rd_req_a, busy_a;
    logic [3:0]  wr_addr_a, rd_addr_a;
    logic [31:0] wr_data_a;
    logic [31:0] rd_data_a = '0;

    logic        sda_oe_b, wr_valid_b, rd_req_b, busy_b;
    logic [3:0]  wr_addr_b, rd_addr_b;
    logic [7:0]  wr_data_b;
    logic [7:0]  rd_data_b = '0;

    assign scl_a   = sel_b ? 1'b1 : scl_m;
    assign sda_a   = (sel_b ? 1'b1 : sda_m) & ~sda_oe_a;
    assign scl_b   = sel_b ? scl_m : 1'b1;
    assign sda_b   = (sel_b ? sda_m : 1'b1) & ~sda_oe_b;
    assign bus_sda = sel_b ? sda_b : sda_a;

    i2c_target_regport #(.DEV_ADDR(7'h50), .PTR_BYTES(2), .DATA_BYTES(4), .NUM_REGS(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .scl_i(scl_a), .sda_i(sda_a), .sda_oe(sda_oe_a),
        .wr_valid(wr_valid_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_req(rd_req_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a)
    );

    i2c_target_regport #(.DEV_ADDR(7'h50), .PTR_BYTES(1), .DATA_BYTES(1), .NUM_REGS(16), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .scl_i(scl_b), .sda_i(sda_b), .sda_oe(sda_oe_b),
        .wr_valid(wr_valid_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [NR];
    logic [31:0] ref_mem [NR];
    int          ref_ptr = 0;
    logic [7:0]  dbuf [0:15];

    logic [3:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  rq      [$];
    logic [3:0]  wbq_addr[$];
    logic [7:0]  wbq_data[$];
    bit          oe_seen = 1'b0;
    bit          strobe_seen = 1'b0;

    // User side: memory written by wr_valid, rd_data returned on the cycle after rd_req.
    always @(negedge clk) begin
        if (wr_valid_a) begin
            wq_addr.push_back(wr_addr_a);
            wq_data.push_back(wr_data_a);
            mem[wr_addr_a] = wr_data_a;
        end
        if (rd_req_a) begin
            rq.push_back(rd_addr_a);
            rd_data_a = mem[rd_addr_a];
        end
        if (wr_valid_b) begin
            wbq_addr.push_back(wr_addr_b);
            wbq_data.push_back(wr_data_b);
        end
        if (rd_req_b) rd_data_b = 8'h00;
        if (sda_oe_a) oe_seen = 1'b1;
        if (wr_valid_a || rd_req_a) strobe_seen = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] ref_byte(input int p, input int k);
        logic [31:0] w;
        w = ref_mem[(p + k / DB) % NR];
        return w[8*(DB-1-(k % DB)) +: 8];
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        wait_cyc(2);
        sda_m = b;
        wait_cyc(3);
        scl_m = 1'b1;
        wait_cyc(2);
        r = bus_sda;
        wait_cyc(3);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1;
        wait_cyc(4);
        scl_m = 1'b1;
        wait_cyc(4);
        sda_m = 1'b0;
        wait_cyc(4);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0;
        wait_cyc(4);
        scl_m = 1'b1;
        wait_cyc(4);
        sda_m = 1'b1;
        wait_cyc(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
        xfer_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, r);
            b[i] = r;
        end
        xfer_bit(~ack, r);
    endtask

    task automatic do_write(input logic [15:0] p, input int n, input string tag);
        logic        ack;
        logic [7:0]  frame [0:18];
        logic [31:0] w;
        int          nfull, a;
        frame[0] = 8'hA0;
        frame[1] = p[15:8];
        frame[2] = p[7:0];
        for (int k = 0; k < n; k++) frame[3+k] = dbuf[k];
        wq_addr.delete();
        wq_data.delete();
        i2c_start;
        for (int k = 0; k < n + 3; k++) begin
            send_byte(frame[k], ack);
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL %s_ack%0d: got ack=%b expected 1", tag, k, ack);
            end
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: got %b expected 1", tag, busy_a);
        end
        i2c_stop;
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_stop: got %b expected 0", tag, busy_a);
        end
        nfull = n / DB;
        checks++;
        if (wq_addr.size() != nfull) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d expected %0d", tag, wq_addr.size(), nfull);
        end
        for (int wi = 0; wi < nfull; wi++) begin
            w = '0;
            for (int k = 0; k < DB; k++) w = (w << 8) | 32'(dbuf[wi*DB + k]);
            a = (int'(p) + wi) % NR;
            if (wi < wq_addr.size()) begin
                checks++;
                if (wq_addr[wi] !== 4'(a) || wq_data[wi] !== w) begin
                    errors++;
                    $display("FAIL %s_wr%0d: got addr %0d data %h expected addr %0d data %h",
                             tag, wi, wq_addr[wi], wq_data[wi], a, w);
                end
            end
            ref_mem[a] = w;
        end
        ref_ptr = (int'(p) + nfull) % NR;
    endtask

    task automatic do_read(input logic [15:0] p, input int n, input string tag);
        logic       ack;
        logic [7:0] b, exp;
        int         nreq;
        rq.delete();
        i2c_start;
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack_w: got %b expected 1", tag, ack); end
        send_byte(p[15:8], ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack_ph: got %b expected 1", tag, ack); end
        send_byte(p[7:0], ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack_pl: got %b expected 1", tag, ack); end
        i2c_start;
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack_r: got %b expected 1", tag, ack); end
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, b);
            exp = ref_byte(int'(p), k);
            checks++;
            if (b !== exp) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h expected %h", tag, k, b, exp);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_nack: got %b expected 0", tag, busy_a);
        end
        i2c_stop;
        nreq = (n + DB - 1) / DB;
        checks++;
        if (rq.size() != nreq) begin
            errors++;
            $display("FAIL %s_rd_count: got %0d expected %0d", tag, rq.size(), nreq);
        end
        for (int j = 0; j < nreq && j < rq.size(); j++) begin
            checks++;
            if (rq[j] !== 4'((int'(p) + j) % NR)) begin
                errors++;
                $display("FAIL %s_rd_addr%0d: got %0d expected %0d", tag, j, rq[j], (int'(p) + j) % NR);
            end
        end
        ref_ptr = (int'(p) + (n - 1) / DB) % NR;
    endtask

    task automatic test_reset;
        checks++;
        if ({sda_oe_a, wr_valid_a, rd_req_a, busy_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_a: got oe/wv/rr/busy %b expected 0000", {sda_oe_a, wr_valid_a, rd_req_a, busy_a});
        end
        checks++;
        if ({sda_oe_b, wr_valid_b, rd_req_b, busy_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_b: got oe/wv/rr/busy %b expected 0000", {sda_oe_b, wr_valid_b, rd_req_b, busy_b});
        end
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(4);
        checks++;
        if ({sda_oe_a, wr_valid_a, rd_req_a, busy_a} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_a: got oe/wv/rr/busy %b expected 0000", {sda_oe_a, wr_valid_a, rd_req_a, busy_a});
        end
    endtask

    task automatic test_write_burst;
        for (int k = 0; k < 8; k++) dbuf[k] = 8'(8'h11 * (k + 1));
        do_write(16'h0003, 8, "wburst");
    endtask

    task automatic test_random_read;
        mem[15] = 32'hDEADBEEF; ref_mem[15] = 32'hDEADBEEF;
        mem[0]  = 32'hCAFEF00D; ref_mem[0]  = 32'hCAFEF00D;
        do_read(16'h000F, 8, "rdburst");
    endtask

    task automatic test_mismatch;
        logic ack;
        oe_seen = 1'b0;
        strobe_seen = 1'b0;
        i2c_start;
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL mis_ack: got ack=%b expected 0", ack); end
        send_byte(8'($urandom), ack);
        send_byte(8'($urandom), ack);
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL mis_busy: got %b expected 0", busy_a); end
        i2c_stop;
        checks++;
        if (oe_seen !== 1'b0) begin errors++; $display("FAIL mis_oe: got sda_oe seen=%b expected 0", oe_seen); end
        checks++;
        if (strobe_seen !== 1'b0) begin errors++; $display("FAIL mis_strobe: got %b expected 0", strobe_seen); end
    endtask

    task automatic test_partial_stop;
        logic       ack;
        logic [7:0] fr [0:4];
        fr[0] = 8'hA0; fr[1] = 8'h00; fr[2] = 8'h01; fr[3] = 8'hAA; fr[4] = 8'hBB;
        wq_addr.delete();
        wq_data.delete();
        i2c_start;
        for (int k = 0; k < 5; k++) begin
            send_byte(fr[k], ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL part_ack%0d: got %b expected 1", k, ack); end
        end
        i2c_stop;
        checks++;
        if (wq_addr.size() != 0) begin
            errors++;
            $display("FAIL part_nowr: got %0d writes expected 0", wq_addr.size());
        end
        for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
        do_write(16'h0001, 4, "part_full");
    endtask

    task automatic test_random;
        logic [15:0] p;
        int          n;
        for (int it = 0; it < 8; it++) begin
            p = 16'($urandom);
            n = $urandom_range(1, 10);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < n; k++) dbuf[k] = 8'($urandom);
                do_write(p, n, $sformatf("rnd%0d_wr", it));
            end else begin
                do_read(p, n, $sformatf("rnd%0d_rd", it));
            end
        end
    endtask

    task automatic test_async_reset;
        logic       ack, got;
        logic [7:0] b;
        int         old_ptr;
        old_ptr = ref_ptr;
        mem[old_ptr] = 32'h01234567;
        ref_mem[old_ptr] = 32'h01234567;
        rq.delete();
        i2c_start;
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL ar_ack: got %b expected 1", ack); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (sda_oe_a) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL ar_drive_wait: got sda_oe=%b expected 1 within 20 cycles", got); end
        checks++;
        if (rq.size() != 1 || rq[0] !== 4'(old_ptr)) begin
            errors++;
            $display("FAIL ar_cur_addr: got %0d reqs expected 1 at addr %0d", rq.size(), old_ptr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sda_oe_a !== 1'b0) begin errors++; $display("FAIL ar_oe_async: got %b expected 0", sda_oe_a); end
        checks++;
        if ({wr_valid_a, rd_req_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL ar_outs: got wv/rr/busy %b expected 000", {wr_valid_a, rd_req_a, busy_a});
        end
        @(negedge clk);
        rst = 1'b0;
        i2c_stop;
        rq.delete();
        i2c_start;
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL ar_ack2: got %b expected 1", ack); end
        recv_byte(1'b0, b);
        checks++;
        if (b !== ref_byte(0, 0)) begin errors++; $display("FAIL ar_byte: got %h expected %h", b, ref_byte(0, 0)); end
        i2c_stop;
        checks++;
        if (rq.size() != 1 || rq[0] !== 4'd0) begin
            errors++;
            $display("FAIL ar_ptr_reset: got %0d reqs expected 1 at addr 0", rq.size());
        end
        ref_ptr = 0;
        for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
        do_write(16'($urandom), 4, "ar_after");
    endtask

    task automatic test_small_build;
        logic       ack;
        logic [7:0] pb, db;
        sel_b = 1'b1;
        wait_cyc(4);
        for (int it = 0; it < 2; it++) begin
            pb = (it == 0) ? 8'h05 : 8'($urandom);
            db = (it == 0) ? 8'h7E : 8'($urandom);
            wbq_addr.delete();
            wbq_data.delete();
            i2c_start;
            send_byte(8'hA0, ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL sb%0d_ack_a: got %b expected 1", it, ack); end
            send_byte(pb, ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL sb%0d_ack_p: got %b expected 1", it, ack); end
            send_byte(db, ack);
            checks++;
            if (ack !== 1'b1) begin errors++; $display("FAIL sb%0d_ack_d: got %b expected 1", it, ack); end
            i2c_stop;
            checks++;
            if (wbq_addr.size() != 1 || wbq_addr[0] !== 4'(pb % NR) || wbq_data[0] !== db) begin
                errors++;
                $display("FAIL sb%0d_wr: got %0d writes (first addr %0d data %h) expected 1 at addr %0d data %h",
                         it, wbq_addr.size(), (wbq_addr.size() > 0) ? wbq_addr[0] : 4'd0,
                         (wbq_data.size() > 0) ? wbq_data[0] : 8'd0, pb % NR, db);
            end
        end
        sel_b = 1'b0;
        wait_cyc(4);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        wait_cyc(5);
        test_reset;
        test_write_burst;
        test_random_read;
        test_mismatch;
        test_partial_stop;
        test_random;
        test_async_reset;
        test_small_build;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
